// File: rtl/target_lock_ctrl_pkg.sv
// target_pkg: shared lock-controller constants and types.
// Also imported by the VGA pixel mixer.
package target_pkg;

  localparam int NUM_TARGETS = 16;
  localparam int IDX_W = $clog2(NUM_TARGETS);

  localparam int CTR_X_MIN = 288;
  localparam int CTR_X_MAX = 351;
  localparam int CTR_Y_MIN = 208;
  localparam int CTR_Y_MAX = 271;

  typedef logic [9:0] coord10_t;
  typedef logic [11:0] coord12_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LOCKED
  } lock_state_t;

  function automatic logic in_range12(
    input coord12_t v,
    input coord12_t lo,
    input coord12_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/target_lock_ctrl_box_hit_test.sv
// box_hit_test: point-in-box plus detect check for one table entry.
// any_mode drops the box test so any detected entry counts as a hit.
module box_hit_test
  import target_pkg::*;
(
  input  coord12_t px,
  input  coord12_t py,
  input  coord12_t x_min,
  input  coord12_t x_max,
  input  coord12_t y_min,
  input  coord12_t y_max,
  input  logic     detected,
  input  logic     any_mode,
  output logic     hit
);

  logic in_box;

  assign in_box = in_range12(px, x_min, x_max)
                & in_range12(py, y_min, y_max);

  assign hit = detected & (any_mode | in_box);

endmodule

// File: rtl/target_lock_ctrl.sv
// target_lock_ctrl: click-driven target lock FSM feeding the pixel mixer.
// Optional auto-acquire on frame_start: define TARGET_LOCK_AUTO_EN.
module target_lock_ctrl #(
  parameter int NUM_TARGETS = target_pkg::NUM_TARGETS,
  parameter int LOST_FRAMES = 30,
  parameter int CTR_X_MIN   = target_pkg::CTR_X_MIN,
  parameter int CTR_X_MAX   = target_pkg::CTR_X_MAX,
  parameter int CTR_Y_MIN   = target_pkg::CTR_Y_MIN,
  parameter int CTR_Y_MAX   = target_pkg::CTR_Y_MAX
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         click_l,
  input  logic                         click_r,
  input  logic [9:0]                   mouse_x_pixel,
  input  logic [9:0]                   mouse_y_pixel,
  input  logic [NUM_TARGETS-1:0][9:0]  aim_x_all,
  input  logic [NUM_TARGETS-1:0][9:0]  aim_y_all,
  input  logic [NUM_TARGETS-1:0]       aim_detected_all,
  input  logic [NUM_TARGETS-1:0][11:0] box_x_min_all,
  input  logic [NUM_TARGETS-1:0][11:0] box_x_max_all,
  input  logic [NUM_TARGETS-1:0][11:0] box_y_min_all,
  input  logic [NUM_TARGETS-1:0][11:0] box_y_max_all,
  output logic                         is_locked,
  output logic [$clog2(NUM_TARGETS)-1:0] locked_idx,
  output logic                         center_hit,
  output logic                         lock_event
);

  import target_pkg::lock_state_t;
  import target_pkg::IDLE;
  import target_pkg::SCAN;
  import target_pkg::LOCKED;
  import target_pkg::coord12_t;
  import target_pkg::in_range12;

  localparam int IW = $clog2(NUM_TARGETS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TARGETS - 1);
  localparam logic [7:0] LOST_LAST = 8'(LOST_FRAMES - 1);

  lock_state_t   state;
  logic          click_l_q;
  logic          click_r_q;
  logic          rise_l;
  logic          rise_r;
  logic [IW-1:0] scan_idx;
  coord12_t      scan_x;
  coord12_t      scan_y;
  logic [7:0]    lost_cnt;
  logic          hit;
  logic          scan_any;
  logic          auto_go;
  logic          lock_det;
  logic          in_ctr;

  box_hit_test u_hit (
    .px       (scan_x),
    .py       (scan_y),
    .x_min    (box_x_min_all[scan_idx]),
    .x_max    (box_x_max_all[scan_idx]),
    .y_min    (box_y_min_all[scan_idx]),
    .y_max    (box_y_max_all[scan_idx]),
    .detected (aim_detected_all[scan_idx]),
    .any_mode (scan_any),
    .hit      (hit)
  );

  assign lock_det = aim_detected_all[locked_idx];
  assign in_ctr = lock_det
    & in_range12({2'b00, aim_x_all[locked_idx]},
                 12'(CTR_X_MIN), 12'(CTR_X_MAX))
    & in_range12({2'b00, aim_y_all[locked_idx]},
                 12'(CTR_Y_MIN), 12'(CTR_Y_MAX));

`ifdef TARGET_LOCK_AUTO_EN
  // After a release the next frame_start only re-arms auto-acquire.
  logic auto_block;

  assign auto_go = frame_start & ~auto_block & ~rise_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_block <= 1'b0;
      scan_any   <= 1'b0;
    end else begin
      if (rise_r)
        auto_block <= 1'b1;
      else if (frame_start)
        auto_block <= 1'b0;
      if (state != SCAN)
        scan_any <= ~rise_l;
    end
  end
`else
  assign auto_go  = 1'b0;
  assign scan_any = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      click_l_q  <= 1'b0;
      click_r_q  <= 1'b0;
      rise_l     <= 1'b0;
      rise_r     <= 1'b0;
      scan_idx   <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      lost_cnt   <= '0;
      is_locked  <= 1'b0;
      locked_idx <= '0;
      center_hit <= 1'b0;
      lock_event <= 1'b0;
    end else begin
      click_l_q  <= click_l;
      click_r_q  <= click_r;
      rise_l     <= click_l & ~click_l_q;
      rise_r     <= click_r & ~click_r_q;
      lock_event <= 1'b0;
      if (rise_r) begin
        state      <= IDLE;
        is_locked  <= 1'b0;
        lost_cnt   <= '0;
        center_hit <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise_l || auto_go) begin
              scan_x   <= {2'b00, mouse_x_pixel};
              scan_y   <= {2'b00, mouse_y_pixel};
              scan_idx <= '0;
              state    <= SCAN;
            end
          end
          SCAN: begin
            if (hit) begin
              locked_idx <= scan_idx;
              lost_cnt   <= '0;
              is_locked  <= 1'b1;
              lock_event <= 1'b1;
              state      <= LOCKED;
            end else if (scan_idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
          LOCKED: begin
            if (rise_l) begin
              scan_x     <= {2'b00, mouse_x_pixel};
              scan_y     <= {2'b00, mouse_y_pixel};
              scan_idx   <= '0;
              is_locked  <= 1'b0;
              center_hit <= 1'b0;
              state      <= SCAN;
            end else if (frame_start) begin
              if (lock_det) begin
                lost_cnt   <= '0;
                center_hit <= in_ctr;
              end else if (lost_cnt >= LOST_LAST) begin
                lost_cnt   <= '0;
                is_locked  <= 1'b0;
                center_hit <= 1'b0;
                state      <= IDLE;
              end else begin
                lost_cnt   <= lost_cnt + 8'd1;
                center_hit <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_target_lock_ctrl.sv
// tb_target_lock_ctrl: randomized and directed lock tests.
// Lock events are checked by a scoreboard monitor against a table model.
module tb_target_lock_ctrl;

  import target_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic click_l = 1'b0;
  logic click_r = 1'b0;
  logic [9:0] mouse_x_pixel = '0;
  logic [9:0] mouse_y_pixel = '0;
  logic [15:0][9:0] aim_x_all;
  logic [15:0][9:0] aim_y_all;
  logic [15:0] aim_detected_all;
  logic [15:0][11:0] box_x_min_all;
  logic [15:0][11:0] box_x_max_all;
  logic [15:0][11:0] box_y_min_all;
  logic [15:0][11:0] box_y_max_all;
  logic is_locked;
  logic [3:0] locked_idx;
  logic center_hit;
  logic lock_event;

  typedef struct {
    int idx;
    int at;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_idx = 0;

  target_lock_ctrl #(.LOST_FRAMES(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .click_l          (click_l),
    .click_r          (click_r),
    .mouse_x_pixel    (mouse_x_pixel),
    .mouse_y_pixel    (mouse_y_pixel),
    .aim_x_all        (aim_x_all),
    .aim_y_all        (aim_y_all),
    .aim_detected_all (aim_detected_all),
    .box_x_min_all    (box_x_min_all),
    .box_x_max_all    (box_x_max_all),
    .box_y_min_all    (box_y_min_all),
    .box_y_max_all    (box_y_max_all),
    .is_locked        (is_locked),
    .locked_idx       (locked_idx),
    .center_hit       (center_hit),
    .lock_event       (lock_event)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every lock_event must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && lock_event) begin
      if (sb.size() == 0) begin
        check("unexpected_lock_event", 1, 0);
      end else begin
        e = sb.pop_front();
        check("lock_idx", 32'(locked_idx), e.idx);
        check("lock_cycle", cyc, e.at);
        check("lock_is_locked", 32'(is_locked), 1);
      end
    end
  end

  function automatic int ref_pick(input int mx, input int my,
                                  input bit any);
    for (int i = 0; i < 16; i++) begin
      if (aim_detected_all[i] &&
          (any ||
           (mx >= int'(box_x_min_all[i]) && mx <= int'(box_x_max_all[i]) &&
            my >= int'(box_y_min_all[i]) && my <= int'(box_y_max_all[i]))))
        return i;
    end
    return -1;
  endfunction

  function automatic int ref_ctr(input int x, input int y);
    return (x >= 288 && x <= 351 && y >= 208 && y <= 271) ? 1 : 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    aim_detected_all = '0;
    for (int i = 0; i < 16; i++) begin
      aim_x_all[i] = '0;
      aim_y_all[i] = '0;
      box_x_min_all[i] = 12'd4000;
      box_x_max_all[i] = 12'd0;
      box_y_min_all[i] = 12'd4000;
      box_y_max_all[i] = 12'd0;
    end
  endtask

  task automatic set_box(input int i, input int x0, input int x1,
                         input int y0, input int y1);
    aim_detected_all[i] = 1'b1;
    box_x_min_all[i] = 12'(x0);
    box_x_max_all[i] = 12'(x1);
    box_y_min_all[i] = 12'(y0);
    box_y_max_all[i] = 12'(y1);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic do_click(input int mx, input int my);
    int k;
    int c0;
    logic was;
    exp_t e;
    mouse_x_pixel = 10'(mx);
    mouse_y_pixel = 10'(my);
    k = ref_pick(mx, my, 1'b0);
    was = is_locked;
    c0 = cyc;
    if (k >= 0) begin
      e.idx = k;
      e.at = c0 + 3 + k;
      sb.push_back(e);
      exp_idx = k;
    end
    click_l = 1'b1;
    tick(1);
    click_l = 1'b0;
    tick(1);
    if (was)
      check("rescan_drops_lock", 32'(is_locked), 0);
    if (k >= 0) begin
      tick(k + 2);
      check("click_locked", 32'(is_locked), 1);
      check("click_idx", 32'(locked_idx), k);
    end else begin
      tick(18);
      check("miss_unlocked", 32'(is_locked), 0);
    end
  endtask

  task automatic release_lock();
    click_r = 1'b1;
    tick(1);
    click_r = 1'b0;
    tick(1);
    check("release_unlock", 32'(is_locked), 0);
    check("release_ctr", 32'(center_hit), 0);
    check("release_idx_hold", 32'(locked_idx), exp_idx);
  endtask

  task automatic both_click();
    click_l = 1'b1;
    click_r = 1'b1;
    tick(1);
    click_l = 1'b0;
    click_r = 1'b0;
  endtask

  initial begin
    int pts[6][2];
    int mx;
    int my;
    int t;
    exp_t e;
    int c0;
    clear_table();
    tick(3);
    check("rst_is_locked", 32'(is_locked), 0);
    check("rst_idx", 32'(locked_idx), 0);
    check("rst_ctr", 32'(center_hit), 0);
    check("rst_event", 32'(lock_event), 0);
    reset = 1'b0;
    tick(2);

    set_box(5, 100, 150, 80, 120);
    do_click(120, 100);

    release_lock();
    clear_table();
    set_box(3, 150, 250, 150, 250);
    set_box(7, 180, 220, 190, 210);
    do_click(200, 200);
    do_click(600, 470);
    check("miss_idx_hold", 32'(locked_idx), exp_idx);
    do_click(600, 470);

    clear_table();
    set_box(0, 0, 1023, 0, 1023);
    aim_x_all[0] = 10'd320;
    aim_y_all[0] = 10'd240;
    do_click(10, 10);
    check("ctr_before_frame", 32'(center_hit), 0);
    frame();
    check("ctr_center", 32'(center_hit), ref_ctr(320, 240));
    aim_x_all[0] = 10'd352;
    tick(3);
    check("ctr_mid_frame", 32'(center_hit), 1);
    frame();
    check("ctr_right_out", 32'(center_hit), ref_ctr(352, 240));
    pts = '{'{351, 271}, '{288, 208}, '{287, 240},
            '{320, 272}, '{320, 207}, '{351, 208}};
    foreach (pts[i]) begin
      aim_x_all[0] = 10'(pts[i][0]);
      aim_y_all[0] = 10'(pts[i][1]);
      frame();
      check("ctr_edge", 32'(center_hit), ref_ctr(pts[i][0], pts[i][1]));
    end

    aim_x_all[0] = 10'd320;
    aim_y_all[0] = 10'd240;
    aim_detected_all[0] = 1'b0;
    frame();
    check("loss1_locked", 32'(is_locked), 1);
    check("loss1_ctr", 32'(center_hit), 0);
    frame();
    check("loss2_locked", 32'(is_locked), 1);
    aim_detected_all[0] = 1'b1;
    frame();
    check("seen_locked", 32'(is_locked), 1);
    check("seen_ctr", 32'(center_hit), 1);
    aim_detected_all[0] = 1'b0;
    frame();
    frame();
    check("restart_locked", 32'(is_locked), 1);
    frame();
    check("loss3_unlocked", 32'(is_locked), 0);
    check("loss3_ctr", 32'(center_hit), 0);
    check("loss3_idx_hold", 32'(locked_idx), exp_idx);

    clear_table();
    set_box(4, 400, 500, 300, 400);
    mouse_x_pixel = 10'd450;
    mouse_y_pixel = 10'd350;
    both_click();
    tick(20);
    check("both_idle", 32'(is_locked), 0);
    do_click(450, 350);
    both_click();
    tick(1);
    check("both_locked_drop", 32'(is_locked), 0);
    tick(20);
    check("both_locked_stay", 32'(is_locked), 0);

    clear_table();
    set_box(15, 0, 1023, 0, 1023);
    click_l = 1'b1;
    tick(1);
    click_l = 1'b0;
    tick(2);
    click_r = 1'b1;
    tick(1);
    click_r = 1'b0;
    tick(25);
    check("abort_scan", 32'(is_locked), 0);

    click_l = 1'b1;
    tick(1);
    click_l = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("rst_scan_locked", 32'(is_locked), 0);
    check("rst_scan_idx", 32'(locked_idx), 0);
    check("rst_scan_ctr", 32'(center_hit), 0);
    check("rst_scan_event", 32'(lock_event), 0);
    reset = 1'b0;
    exp_idx = 0;
    tick(25);
    check("rst_scan_after", 32'(is_locked), 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0)
        release_lock();
      clear_table();
      for (int i = 0; i < 16; i++) begin
        t = $urandom_range(0, 1100);
        box_x_min_all[i] = 12'(t);
        box_x_max_all[i] = 12'(t + $urandom_range(0, 150));
        t = $urandom_range(0, 800);
        box_y_min_all[i] = 12'(t);
        box_y_max_all[i] = 12'(t + $urandom_range(0, 150));
        aim_detected_all[i] = ($urandom_range(0, 2) == 0);
      end
      t = $urandom_range(0, 15);
      mx = int'(box_x_min_all[t]) +
           $urandom_range(0, int'(box_x_max_all[t] - box_x_min_all[t]));
      my = int'(box_y_min_all[t]) +
           $urandom_range(0, int'(box_y_max_all[t] - box_y_min_all[t]));
      if (mx > 1023 || $urandom_range(0, 3) == 0)
        mx = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0)
        my = $urandom_range(0, 1023);
      do_click(mx, my);
    end

`ifdef TARGET_LOCK_AUTO_EN
    release_lock();
    clear_table();
    set_box(2, 900, 910, 900, 910);
    set_box(9, 900, 910, 900, 910);
    frame();
    release_lock();
    c0 = cyc;
    e.idx = ref_pick(0, 0, 1'b1);
    e.at = c0 + 2 + e.idx;
    sb.push_back(e);
    exp_idx = e.idx;
    frame();
    tick(6);
    check("auto_lock", 32'(is_locked), 1);
    check("auto_idx", 32'(locked_idx), 2);
    release_lock();
    frame();
    tick(20);
    check("auto_blocked", 32'(is_locked), 0);
    c0 = cyc;
    e.at = c0 + 2 + e.idx;
    sb.push_back(e);
    frame();
    tick(6);
    check("auto_relock", 32'(is_locked), 1);
`endif

    tick(5);
    check("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
